// File: rtl/mxn_pipe_ctrl_pkg.sv
// Shared definitions for the flow-controlled M x N shift pipeline:
// controller state encoding and the occupancy-counter width helper.
package mxn_pipe_ctrl_pkg;

    // Controller states: RUN accepts input, DRAIN inserts bubbles until empty.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } ctrl_state_t;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mxn_pipe_stage.sv
// One pipeline stage: an M-bit data register plus its valid bit.
// Loads on enable; clr drops the valid bit without touching the data.
module mxn_pipe_stage #(
    parameter int M = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         d_valid,
    input  logic [M-1:0] d_data,
    output logic         q_valid,
    output logic [M-1:0] q_data
);

    // Stage register: reset clears everything, clr kills the valid, en advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else if (clr) begin
            q_valid <= 1'b0;
        end else if (en) begin
            q_valid <= d_valid;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/mxn_pipe_ctrl.sv
// Flow-controlled M-bit x N-stage shift pipeline with global-stall shifting,
// occupancy counter and a drain/flush sequencing controller.
module mxn_pipe_ctrl
    import mxn_pipe_ctrl_pkg::*;
#(
    parameter int M = 3,
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [M-1:0]           in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [M-1:0]           out_data,
    input  logic                   out_ready,
    input  logic                   drain_req,
    input  logic                   flush,
    output logic                   drain_done,
    output logic [$clog2(N+1)-1:0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int CW = count_width(N);

    // Stage buses: *_d feeds each stage, *_q is each stage's registered output.
    logic [N-1:0]   vld_d;
    logic [N-1:0]   vld_q;
    logic [N*M-1:0] dat_d;
    logic [N*M-1:0] dat_q;

    logic        shift_en;
    logic        in_fire;
    logic        out_fire;
    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic        done_d;
    logic        done_q;
    logic [CW-1:0] count_q;

    // Handshake: the whole chain moves together unless the tail is stuck.
    assign shift_en  = ~vld_q[N-1] | out_ready;
    assign in_ready  = shift_en & (state_q == ST_RUN) & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = vld_q[N-1];
    assign out_data  = dat_q[N*M-1 -: M];
    assign out_fire  = out_valid & out_ready;

    // Stage 0 takes the accepted word, or a bubble when nothing is accepted.
    generate
        if (N == 1) begin : g_chain_one
            assign vld_d = in_fire;
            assign dat_d = in_data;
        end else begin : g_chain_many
            assign vld_d = {vld_q[N-2:0], in_fire};
            assign dat_d = {dat_q[(N-1)*M-1:0], in_data};
        end
    endgenerate

    mxn_pipe_stage #(.M(M)) u_stage [N-1:0] (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (shift_en),
        .clr     (flush),
        .d_valid (vld_d),
        .d_data  (dat_d),
        .q_valid (vld_q),
        .q_data  (dat_q)
    );

    // Occupancy counter: +accept -deliver; flush empties it outright.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Controller state register and registered drain_done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next state: drain runs until the last word leaves; flush overrides all.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (drain_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((count_q == '0) || ((count_q == CW'(1)) && out_fire)) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (flush) begin
            state_d = ST_RUN;
            done_d  = 1'b0;
        end
    end

    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(N));
    assign drain_done = done_q;

endmodule

// File: tb/tb_mxn_pipe_ctrl.sv
module tb_mxn_pipe_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    // Main DUT: M=3, N=4
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_ready;
    logic       drain_req;
    logic       flush;
    logic       drain_done;
    logic [2:0] count;
    logic       empty;
    logic       full;

    // Single-stage DUT: M=8, N=1
    logic       b_in_valid;
    logic [7:0] b_in_data;
    logic       b_in_ready;
    logic       b_out_valid;
    logic [7:0] b_out_data;
    logic       b_out_ready;
    logic       b_drain_req;
    logic       b_flush;
    logic       b_drain_done;
    logic [0:0] b_count;
    logic       b_empty;
    logic       b_full;

    int checks = 0;
    int errors = 0;

    mxn_pipe_ctrl #(.M(3), .N(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .drain_req  (drain_req),
        .flush      (flush),
        .drain_done (drain_done),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    mxn_pipe_ctrl #(.M(8), .N(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (b_in_valid),
        .in_data    (b_in_data),
        .in_ready   (b_in_ready),
        .out_valid  (b_out_valid),
        .out_data   (b_out_data),
        .out_ready  (b_out_ready),
        .drain_req  (b_drain_req),
        .flush      (b_flush),
        .drain_done (b_drain_done),
        .count      (b_count),
        .empty      (b_empty),
        .full       (b_full)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        drain_req = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        b_drain_req = 1'b0; b_flush = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 3'd0) begin errors++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %0b/%0b exp 1/0", empty, full); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL reset_drain_done got %0b exp 0", drain_done); end
        checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_n1 got ov=%0b ir=%0b exp 0/1", b_out_valid, b_in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        int ecnt;
        idle_inputs();
        for (int k = 0; k < 12; k++) begin
            in_valid = (k < 8);
            in_data  = 3'(k + 1);
            #1;
            ecnt = ((k < 8) ? k : 8) - (((k < 12) ? k : 12) > 4 ? (((k < 12) ? k : 12) - 4) : 0);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready k=%0d got %0b exp 1", k, in_ready); end
            checks++; if (out_valid !== (k >= 4 && k <= 11)) begin errors++; $display("FAIL stream_out_valid k=%0d got %0b exp %0b", k, out_valid, (k >= 4 && k <= 11)); end
            if (k >= 4 && k <= 11) begin
                checks++; if (out_data !== 3'(k - 3)) begin errors++; $display("FAIL stream_out_data k=%0d got %0d exp %0d", k, out_data, 3'(k - 3)); end
            end
            checks++; if (count !== 3'(ecnt)) begin errors++; $display("FAIL stream_count k=%0d got %0d exp %0d", k, count, ecnt); end
            checks++; if (full !== (ecnt == 4)) begin errors++; $display("FAIL stream_full k=%0d got %0b exp %0b", k, full, (ecnt == 4)); end
            tick();
        end
        idle_inputs();
        checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got empty=%0b ov=%0b exp 1/0", empty, out_valid); end
    endtask

    task automatic test_backpressure();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 3'(2 + k);
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            in_valid  = 1'b1;
            in_data   = 3'd7;
            out_ready = 1'b0;
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready j=%0d got %0b exp 0", j, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_data !== 3'd2) begin errors++; $display("FAIL bp_hold j=%0d got ov=%0b d=%0d exp 1/2", j, out_valid, out_data); end
            checks++; if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL bp_count j=%0d got %0d full=%0b exp 4/1", j, count, full); end
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== 3'(2 + j)) begin errors++; $display("FAIL bp_release j=%0d got ov=%0b d=%0d exp 1/%0d", j, out_valid, out_data, 2 + j); end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL bp_end got ov=%0b cnt=%0d exp 0/0", out_valid, count); end
    endtask

    task automatic test_drain();
        int pulses;
        logic exp_ir;
        pulses = 0;
        idle_inputs();
        for (int k = 0; k < 9; k++) begin
            in_valid  = (k < 2) || (k >= 3 && k < 6);
            in_data   = (k < 2) ? 3'(4 + k) : 3'd1;
            drain_req = (k == 2) || (k == 4);
            #1;
            exp_ir = (k < 3) || (k >= 6);
            checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL drain_in_ready k=%0d got %0b exp %0b", k, in_ready, exp_ir); end
            checks++; if (drain_done !== (k == 6)) begin errors++; $display("FAIL drain_done k=%0d got %0b exp %0b", k, drain_done, (k == 6)); end
            if (drain_done === 1'b1) pulses++;
            checks++; if (out_valid !== (k == 4 || k == 5)) begin errors++; $display("FAIL drain_out_valid k=%0d got %0b exp %0b", k, out_valid, (k == 4 || k == 5)); end
            if (k == 4 || k == 5) begin
                checks++; if (out_data !== 3'(k)) begin errors++; $display("FAIL drain_out_data k=%0d got %0d exp %0d", k, out_data, k); end
            end
            if (k == 6) begin
                checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
            end
            tick();
        end
        idle_inputs();
        checks++; if (pulses != 1) begin errors++; $display("FAIL drain_pulse_count got %0d exp 1", pulses); end
    endtask

    task automatic test_drain_empty();
        idle_inputs();
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || drain_done !== 1'b0) begin errors++; $display("FAIL drain_empty_c1 got ir=%0b dd=%0b exp 0/0", in_ready, drain_done); end
        tick();
        checks++; if (drain_done !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL drain_empty_c2 got dd=%0b ir=%0b exp 1/1", drain_done, in_ready); end
        tick();
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL drain_empty_c3 got %0b exp 0", drain_done); end
    endtask

    task automatic test_flush();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 3'(5 + k);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 3'd3;
        flush    = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b exp 0", in_ready); end
        tick();
        idle_inputs();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL flush_after got cnt=%0d ov=%0b exp 0/0", count, out_valid); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak k=%0d got ov=%0b d=%0d exp 0", k, out_valid, out_data); end
            tick();
        end
    endtask

    task automatic test_flush_drain();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 3'(1 + k);
            tick();
        end
        in_valid  = 1'b0;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drain_req = (k == 0);
            flush     = (k == 0);
            #1;
            checks++; if (drain_done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL fd_no_done k=%0d got dd=%0b ov=%0b exp 0/0", k, drain_done, out_valid); end
            if (k == 1) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fd_flush_wins got ir=%0b exp 1", in_ready); end
            end
            tick();
        end
        idle_inputs();
        checks++; if (count !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL fd_end got cnt=%0d ir=%0b exp 0/1", count, in_ready); end
    endtask

    task automatic test_reset_full();
        idle_inputs();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 3'(4 + k);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (full !== 1'b1 || out_data !== 3'd4) begin errors++; $display("FAIL rf_full got full=%0b d=%0d exp 1/4", full, out_data); end
        rst_n = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 3'd0 || count !== 3'd0) begin errors++; $display("FAIL rf_reset got ov=%0b d=%0d cnt=%0d exp 0/0/0", out_valid, out_data, count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1 || drain_done !== 1'b0) begin errors++; $display("FAIL rf_flags got e=%0b f=%0b ir=%0b dd=%0b exp 1/0/1/0", empty, full, in_ready, drain_done); end
        rst_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_n1();
        logic       mv;
        logic [7:0] md;
        logic [7:0] nxt;
        logic       exp_ir;
        mv  = 1'b0;
        md  = '0;
        nxt = 8'd1;
        for (int k = 0; k < 12; k++) begin
            b_out_ready = (k % 2 == 0);
            b_in_valid  = 1'b1;
            b_in_data   = nxt;
            #1;
            exp_ir = ~mv | b_out_ready;
            checks++; if (b_in_ready !== exp_ir) begin errors++; $display("FAIL n1_in_ready k=%0d got %0b exp %0b", k, b_in_ready, exp_ir); end
            checks++; if (b_out_valid !== mv) begin errors++; $display("FAIL n1_out_valid k=%0d got %0b exp %0b", k, b_out_valid, mv); end
            if (mv) begin
                checks++; if (b_out_data !== md) begin errors++; $display("FAIL n1_out_data k=%0d got %0d exp %0d", k, b_out_data, md); end
            end
            checks++; if (b_count !== mv) begin errors++; $display("FAIL n1_count k=%0d got %0d exp %0d", k, b_count, mv); end
            if (exp_ir) begin
                mv  = 1'b1;
                md  = nxt;
                nxt = nxt + 8'd1;
            end
            tick();
        end
        b_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_drain_empty();
        test_flush();
        test_flush_drain();
        test_reset_full();
        test_n1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
